issue_buffer: RTL and testbench

- Parametrised successor to the dual-issue decode-stage pairing check.
- Sits between fetch and the decode/execute lanes; holds fetched instructions in a circular FIFO of DEPTH entries.
- Each cycle issues the longest hazard-free prefix of up to ISSUE_W instructions from the head.
- Adds operand-aware RAW/WAW checks, control-op group termination, sticky halt, a one-cycle load-use bubble, and flush.

---
 rtl/issue_pkg.sv | 49 ++++
 rtl/issue_pair_check.sv | 29 ++
 rtl/issue_buffer.sv | 160 ++++++++++++++++
 tb/tb_issue_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared decode definitions for the issue buffer: RV32 opcodes, the halt
// encoding and the per-instruction hazard summary used by the pairing checks.
package issue_pkg;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;

    localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

    typedef struct packed {
        logic       we;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       is_load;
        logic       is_store;
        logic       is_ctrl;
        logic       is_halt;
    } inst_info_t;

    function automatic inst_info_t decode_inst(input logic [31:0] instr);
        inst_info_t info;
        logic [6:0] opc;
        opc           = instr[6:0];
        info.rd       = instr[11:7];
        info.rs1      = instr[19:15];
        info.rs2      = instr[24:20];
        info.we       = (opc == OP || opc == OP_IMM || opc == LOAD || opc == LUI ||
                         opc == AUIPC || opc == JAL || opc == JALR) && (instr[11:7] != 5'd0);
        info.uses_rs1 = (opc == OP || opc == OP_IMM || opc == LOAD || opc == STORE ||
                         opc == BRANCH || opc == JALR);
        info.uses_rs2 = (opc == OP || opc == STORE || opc == BRANCH);
        info.is_load  = (opc == LOAD);
        info.is_store = (opc == STORE);
        info.is_ctrl  = (opc == BRANCH || opc == JAL || opc == JALR);
        info.is_halt  = (instr == HALT_INSTR);
        return info;
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Combinational hazard test between an earlier and a later slot of one group;
// a set o_conflict keeps the later slot (and everything after it) out.
module issue_pair_check
    import issue_pkg::*;
(
    input  inst_info_t i_earlier,
    input  inst_info_t i_later,
    output logic       o_conflict
);

    logic w_raw;
    logic w_waw;
    logic w_mem;
    logic w_unused;

    assign w_raw = i_earlier.we &&
                   ((i_later.uses_rs1 && (i_later.rs1 == i_earlier.rd)) ||
                    (i_later.uses_rs2 && (i_later.rs2 == i_earlier.rd)));
    assign w_waw = i_earlier.we && i_later.we && (i_later.rd == i_earlier.rd);
    assign w_mem = i_earlier.is_store && (i_later.is_load || i_later.is_store);

    // A control op or a halt anywhere before this slot closes the group.
    assign o_conflict = w_raw || w_waw || w_mem || i_earlier.is_ctrl ||
                        i_earlier.is_halt || i_later.is_halt;

    assign w_unused = ^{i_earlier.rs1, i_earlier.rs2, i_earlier.uses_rs1,
                        i_earlier.uses_rs2, i_earlier.is_load, i_later.is_ctrl};

endmodule

// File: rtl/issue_buffer.sv
// Circular instruction FIFO that issues the longest hazard-free prefix of up to
// ISSUE_W entries per cycle, with load-use bubble, sticky halt and flush.
module issue_buffer
    import issue_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int ISSUE_W        = 2,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [$clog2(ISSUE_W+1)-1:0] in_count,
    input  logic [32*ISSUE_W-1:0]        in_instr,
    input  logic [32*ISSUE_W-1:0]        in_pc,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [32*ISSUE_W-1:0]        out_instr,
    output logic [32*ISSUE_W-1:0]        out_pc,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(ISSUE_W+1);

    logic [31:0]        r_mem_instr [DEPTH];
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic               r_halted;
    logic [ISSUE_W-1:0] r_lu_valid;
    logic [4:0]         r_lu_rd     [ISSUE_W];

    logic [31:0]        w_slot_instr [ISSUE_W];
    logic [31:0]        w_slot_pc    [ISSUE_W];
    inst_info_t         w_info       [ISSUE_W];
    logic [ISSUE_W-1:0] w_conf       [ISSUE_W];
    logic               w_lu_hit;
    logic [ISSUE_W-1:0] w_group;
    logic [NW-1:0]      w_n;
    logic               w_push;
    logic               w_pop;

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
        assign w_slot_instr[k] = r_mem_instr[r_head + PW'(k)];
        assign w_slot_pc[k]    = r_mem_pc[r_head + PW'(k)];
        assign w_info[k]       = decode_inst(w_slot_instr[k]);
        for (genvar j = 0; j < ISSUE_W; j++) begin : g_pair
            if (j < k) begin : g_chk
                issue_pair_check u_pair (
                    .i_earlier  (w_info[j]),
                    .i_later    (w_info[k]),
                    .o_conflict (w_conf[k][j])
                );
            end else begin : g_none
                assign w_conf[k][j] = 1'b0;
            end
        end
    end

    always_comb begin
        w_lu_hit = 1'b0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if ((LOAD_USE_STALL != 0) && r_lu_valid[i] &&
                ((w_info[0].uses_rs1 && (w_info[0].rs1 == r_lu_rd[i])) ||
                 (w_info[0].uses_rs2 && (w_info[0].rs2 == r_lu_rd[i])))) begin
                w_lu_hit = 1'b1;
            end
        end
    end

    // NOTE: flush gates the group combinationally so nothing issues in the flush cycle.
    always_comb begin
        w_group    = '0;
        w_group[0] = !flush && !r_halted && (r_count != '0) && !w_lu_hit;
        for (int k = 1; k < ISSUE_W; k++) begin
            w_group[k] = w_group[k-1] && (int'(r_count) > k) && (w_conf[k] == '0);
        end
    end

    always_comb begin
        w_n = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_n = w_n + NW'(w_group[k]);
        end
    end

    assign in_ready = (CW'(DEPTH) - r_count) >= CW'(ISSUE_W);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = out_ready && (w_n != '0);

    always_comb begin
        out_valid = w_group;
        out_instr = '0;
        out_pc    = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (w_group[k]) begin
                out_instr[32*k +: 32] = w_slot_instr[k];
                out_pc[32*k +: 32]    = w_slot_pc[k];
            end
        end
    end

    assign halted = r_halted;
    assign count  = r_count;

    // NOTE: storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (k < int'(in_count)) begin
                    r_mem_instr[r_tail + PW'(k)] <= in_instr[32*k +: 32];
                    r_mem_pc[r_tail + PW'(k)]    <= in_pc[32*k +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_halted   <= 1'b0;
            r_lu_valid <= '0;
            for (int k = 0; k < ISSUE_W; k++) begin
                r_lu_rd[k] <= '0;
            end
        end else if (flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_lu_valid <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(in_count);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(w_n);
            end
            r_count <= r_count + (w_push ? CW'(in_count) : CW'(0))
                               - (w_pop ? CW'(w_n) : CW'(0));
            if (out_ready) begin
                for (int k = 0; k < ISSUE_W; k++) begin
                    r_lu_valid[k] <= w_group[k] && w_info[k].is_load && w_info[k].we;
                    r_lu_rd[k]    <= w_info[k].rd;
                end
            end
            if (w_pop && w_info[0].is_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_issue_buffer.sv
// Self-checking bench for issue_buffer: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_issue_buffer;

    localparam int DEPTH   = 8;
    localparam int ISSUE_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_count;
    logic [63:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
    logic [3:0]  count;

    issue_buffer #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .LOAD_USE_STALL(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .halted    (halted),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    bit          m_halted;
    bit   [31:0] m_lu;      // registers written by loads issued in the last accepted cycle
    logic [31:0] next_pc;

    function automatic bit writes_reg(logic [31:0] x);
        case (x[6:0])
            7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: return x[11:7] != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] read_mask(logic [31:0] x);
        bit [31:0] m;
        m = '0;
        if (x[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) m[x[19:15]] = 1'b1;
        if (x[6:0] inside {7'h33, 7'h23, 7'h63}) m[x[24:20]] = 1'b1;
        return m;
    endfunction

    function automatic bit is_mem(logic [31:0] x);
        return x[6:0] == 7'h03 || x[6:0] == 7'h23;
    endfunction

    function automatic bit is_ctrl(logic [31:0] x);
        return x[6:0] inside {7'h63, 7'h6F, 7'h67};
    endfunction

    function automatic int model_group(input bit fl);
        bit [31:0] wmask;
        bit seen_store, seen_ctrl, seen_halt;
        int n;
        logic [31:0] x;
        if (fl || m_halted || q_instr.size() == 0) return 0;
        if ((read_mask(q_instr[0]) & m_lu) != 0) return 0;
        wmask = '0; seen_store = 0; seen_ctrl = 0; seen_halt = 0; n = 0;
        for (int k = 0; k < ISSUE_W && k < q_instr.size(); k++) begin
            x = q_instr[k];
            if (k > 0) begin
                if (x == 32'h73 || seen_halt || seen_ctrl) break;
                if ((read_mask(x) & wmask) != 0) break;
                if (writes_reg(x) && wmask[x[11:7]]) break;
                if (is_mem(x) && seen_store) break;
            end
            n++;
            if (writes_reg(x)) wmask[x[11:7]] = 1'b1;
            if (x[6:0] == 7'h23) seen_store = 1;
            if (is_ctrl(x)) seen_ctrl = 1;
            if (x == 32'h73) seen_halt = 1;
        end
        return n;
    endfunction

    task automatic model_reset();
        q_instr.delete();
        q_pc.delete();
        m_halted = 0;
        m_lu     = '0;
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model.
    task automatic step(input bit v, input int cnt, input logic [31:0] a, input logic [31:0] b,
                        input bit fl, input bit ordy);
        int n;
        bit rdy;
        logic [63:0] ei, ep;
        in_valid  = v;
        in_count  = 2'(cnt);
        in_instr  = {b, a};
        in_pc     = {next_pc + 32'd4, next_pc};
        flush     = fl;
        out_ready = ordy;
        @(negedge clk);
        n   = model_group(fl);
        rdy = (DEPTH - q_instr.size()) >= ISSUE_W;
        ei  = '0;
        ep  = '0;
        for (int k = 0; k < n; k++) begin
            ei[32*k +: 32] = q_instr[k];
            ep[32*k +: 32] = q_pc[k];
        end
        check("out_valid", 64'(out_valid), 64'((1 << n) - 1));
        check("out_instr", out_instr, ei);
        check("out_pc", out_pc, ep);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("count", 64'(count), 64'(q_instr.size()));
        check("halted", 64'(halted), 64'(m_halted));
        if (fl) begin
            q_instr.delete();
            q_pc.delete();
            m_lu = '0;
        end else begin
            if (ordy) begin
                m_lu = '0;
                for (int k = 0; k < n; k++)
                    if (q_instr[k][6:0] == 7'h03 && writes_reg(q_instr[k])) m_lu[q_instr[k][11:7]] = 1'b1;
                if (n > 0 && q_instr[0] == 32'h73) m_halted = 1;
                repeat (n) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
            end
            if (v && rdy) begin
                q_instr.push_back(a);
                q_pc.push_back(next_pc);
                if (cnt > 1) begin
                    q_instr.push_back(b);
                    q_pc.push_back(next_pc + 32'd4);
                end
                next_pc = next_pc + 32'(4 * cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [31:0] a, input logic [31:0] b, input bit ordy);
        step(1, 2, a, b, 0, ordy);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) step(0, 1, 32'h0, 32'h0, 0, 1);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] e_addi(int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] e_add(int rd, int rs1, int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] e_lw(int rd, int rs1, int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction
    function automatic logic [31:0] e_sw(int rs2, int rs1, int imm);
        logic [11:0] i;
        i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'b010, i[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_beq(int rs1, int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'b01000, 7'h63};
    endfunction
    function automatic logic [31:0] e_lui(int rd, int imm);
        return {20'(imm), 5'(rd), 7'h37};
    endfunction
    function automatic logic [31:0] e_jal(int rd);
        return {20'h00400, 5'(rd), 7'h6F};
    endfunction
    function automatic logic [31:0] e_jalr(int rd, int rs1);
        return {12'h000, 5'(rs1), 3'b000, 5'(rd), 7'h67};
    endfunction

    function automatic logic [31:0] rand_instr();
        int r1, r2, r3;
        r1 = $urandom_range(0, 5);
        r2 = $urandom_range(0, 5);
        r3 = $urandom_range(0, 5);
        case ($urandom_range(0, 8))
            0, 1: return e_addi(r1, r2, $urandom_range(0, 100));
            2, 3: return e_add(r1, r2, r3);
            4:    return e_lw(r1, r2, 4 * $urandom_range(0, 15));
            5:    return e_sw(r1, r2, 4 * $urandom_range(0, 15));
            6:    return e_beq(r1, r2);
            7:    return e_lui(r1, $urandom_range(1, 999));
            default: return ($urandom_range(0, 1) != 0) ? e_jal(r1) : e_jalr(r1, r2);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 0; in_count = 0; in_instr = '0; in_pc = '0;
        flush = 0; out_ready = 0;
        next_pc = 32'h1000;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_halted", 64'(halted), 64'd0);
        rst = 1'b0;

        // independent pair issues together
        push2(e_addi(1, 0, 1), e_addi(2, 0, 2), 1);
        check("pair_valid", 64'(out_valid), 64'h3);
        idle(2);
        // RAW splits the pair
        push2(e_addi(5, 0, 1), e_add(6, 5, 5), 1);
        check("raw_first", 64'(out_valid), 64'h1);
        idle(3);
        // WAW splits, disjoint LUIs pair up
        push2(e_lui(5, 1), e_lui(5, 2), 1);
        check("waw_single", 64'(out_valid), 64'h1);
        idle(3);
        push2(e_lui(5, 1), e_lui(7, 2), 1);
        check("lui_pair", 64'(out_valid), 64'h3);
        idle(2);
        // store then load
        push2(e_sw(1, 2, 0), e_lw(3, 2, 4), 1);
        check("st_ld_first", 64'(out_valid), 64'h1);
        idle(3);
        // load-use bubble
        push2(e_lw(4, 0, 0), e_add(5, 4, 0), 1);
        step(0, 1, 0, 0, 0, 1);
        check("lu_bubble", 64'(out_valid), 64'h0);
        check("lu_bubble_count", 64'(count), 64'd1);
        idle(3);
        // branch ends the group
        push2(e_beq(0, 0), e_addi(1, 0, 1), 1);
        check("ctrl_first", 64'(out_valid), 64'h1);
        idle(3);

        // fill to full with back-end stalled, then drain across the wrap
        for (int b = 0; b < 4; b++) push2(e_addi(2*b+1, 0, b), e_addi(2*b+2, 0, b), 0);
        check("full_count", 64'(count), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        push2(e_addi(9, 0, 9), e_addi(10, 0, 9), 0);
        idle(6);

        // flush with six entries and a concurrent push
        for (int b = 0; b < 3; b++) push2(e_addi(1, 0, b), e_addi(2, 0, b), 0);
        check("pre_flush_count", 64'(count), 64'd6);
        step(1, 2, e_addi(3, 0, 0), e_addi(4, 0, 0), 1, 1);
        check("flush_count", 64'(count), 64'd0);
        idle(1);

        // random traffic against the model
        for (int c = 0; c < 500; c++)
            step($urandom_range(0, 3) != 0, $urandom_range(1, 2), rand_instr(), rand_instr(),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);

        // asynchronous reset in the middle of a pending group
        step(1, 1, 32'h0, 32'h0, 1, 0);
        push2(e_addi(1, 0, 1), e_addi(2, 0, 2), 0);
        check("pre_rst_valid", 64'(out_valid), 64'h3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        in_valid = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // halt issues alone and then freezes issue
        push2(e_addi(1, 0, 1), 32'h0000_0073, 1);
        check("halt_pre", 64'(out_valid), 64'h1);
        step(0, 1, 0, 0, 0, 1);
        check("halt_alone", 64'(out_valid), 64'h1);
        idle(1);
        check("halted_set", 64'(halted), 64'd1);
        push2(e_addi(1, 0, 1), e_addi(2, 0, 2), 1);
        idle(2);
        step(1, 1, 32'h0, 32'h0, 1, 1);
        check("halt_survives_flush", 64'(halted), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
